// File: rtl/time_pkg.sv
// Shared time-of-day types and limits for the time base and the data checker.
package time_pkg;
    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef logic [TIME_W-1:0] time_t;
endpackage

// File: rtl/time_base_if.sv
// Control/preset and time-value signals between the time base and its users.
interface time_base_if;
    logic              en;
    logic              set_valid;
    time_pkg::time_t   set_min;
    time_pkg::time_t   set_sec;
    logic              set_err;
    time_pkg::time_t   seconds;
    time_pkg::time_t   minutes;
    logic              sec_tick;
    logic              min_tick;
    logic              hour_tick;

    modport master (
        output en, set_valid, set_min, set_sec,
        input  set_err, seconds, minutes, sec_tick, min_tick, hour_tick
    );

    modport slave (
        input  en, set_valid, set_min, set_sec,
        output set_err, seconds, minutes, sec_tick, min_tick, hour_tick
    );
endinterface

// File: rtl/time_base_tick_gen.sv
// Clock prescaler: raises tick1hz on the edge where the count wraps at CLK_HZ-1.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick1hz
);
    localparam int            PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_cnt;
    logic          w_at_tc;

    assign w_at_tc = (r_cnt == TC);
    // A clear at terminal count restarts the second instead of completing it.
    assign tick1hz = en && w_at_tc && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_tc ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/time_base.sv
// Seconds/minutes time base with synchronous preset and registered tick strobes.
module time_base
    import time_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    time_base_if.slave  bus
);
    localparam time_t SEC_LAST = TIME_W'(SEC_MAX);
    localparam time_t MIN_LAST = TIME_W'(MIN_MAX);

    time_t r_sec;
    time_t r_min;
    logic  r_sec_tick;
    logic  r_min_tick;
    logic  r_hour_tick;
    logic  r_set_err;

    logic  w_set_ok;
    logic  w_set_bad;
    logic  w_tick1hz;

    assign w_set_ok  = bus.set_valid && (bus.set_min <= MIN_LAST) && (bus.set_sec <= SEC_LAST);
    assign w_set_bad = bus.set_valid && !w_set_ok;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .clr     (w_set_ok),
        .tick1hz (w_tick1hz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec       <= '0;
            r_min       <= '0;
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_set_err   <= w_set_bad;
            if (w_set_ok) begin
                r_sec <= bus.set_sec;
                r_min <= bus.set_min;
            end else if (w_tick1hz) begin
                r_sec_tick <= 1'b1;
                // minutes only moves here, so the downstream checker sees one clean step
                if (r_sec >= SEC_LAST) begin
                    r_sec      <= '0;
                    r_min_tick <= 1'b1;
                    if (r_min >= MIN_LAST) begin
                        r_min       <= '0;
                        r_hour_tick <= 1'b1;
                    end else begin
                        r_min <= r_min + 1'b1;
                    end
                end else begin
                    r_sec <= r_sec + 1'b1;
                end
            end
        end
    end

    assign bus.seconds   = r_sec;
    assign bus.minutes   = r_min;
    assign bus.sec_tick  = r_sec_tick;
    assign bus.min_tick  = r_min_tick;
    assign bus.hour_tick = r_hour_tick;
    assign bus.set_err   = r_set_err;
endmodule
